limbus_cpu_debug_cmd_engine: RTL and testbench

LIMBUS_CPU_DEBUG_CMD_ENGINE -- requirements
Module: limbus_cpu_debug_cmd_engine

---
 rtl/limbus_cpu_debug_cmd_engine.sv | 186 ++++++++++++++++++
 tb/tb_limbus_cpu_debug_cmd_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limbus_cpu_debug_cmd_engine.sv
// Debug command engine: serial shift register, per-channel take-action / no-action handshake.
// Optional build macro LIMBUS_DBG_PARITY_EN enables an even-parity check on bit SR_W-2 at update.
module limbus_cpu_debug_cmd_engine #(
    parameter int IR_W   = 2,
    parameter int SR_W   = 38,
    parameter int NUM_CH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dbg_ir_load,
    input  logic [IR_W-1:0]          dbg_ir_in,
    input  logic                     dbg_capture,
    input  logic                     dbg_shift,
    input  logic                     dbg_tdi,
    output logic                     dbg_tdo,
    input  logic                     dbg_update,
    input  logic [NUM_CH*SR_W-1:0]   ch_rdata,
    input  logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_action,
    output logic [NUM_CH-1:0]        ch_noaction,
    output logic [SR_W-1:0]          jdo,
    output logic                     busy,
    output logic                     err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTION = 2'd1,
        ST_NOACT  = 2'd2
    } state_e;

    localparam logic [IR_W:0]   NUM_CH_W = (IR_W+1)'(NUM_CH);
    localparam logic [IR_W-1:0] IR_ONES  = {IR_W{1'b1}};
    localparam logic [SR_W-1:0] SR_BUSY  = {1'b1, {(SR_W-1){1'b0}}};

    state_e              state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [IR_W-1:0]     cur_ch_q, cur_ch_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [SR_W-1:0]     jdo_q, jdo_d;
    logic [NUM_CH-1:0]   action_q, action_d;
    logic [NUM_CH-1:0]   noaction_q, noaction_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                ir_valid_s;
    logic [SR_W-1:0]     rd_word_s;
    logic                ack_s;
    logic [NUM_CH-1:0]   ir_onehot_s;
    logic                par_bad_s;
    logic                upd_take_s;
    logic                upd_drop_s;
    logic                set_err_s;

`ifdef LIMBUS_DBG_PARITY_EN
    function automatic logic even_par(input logic [SR_W-1:0] w);
        even_par = ^{w[SR_W-1], w[SR_W-3:0]};
    endfunction

    assign par_bad_s = (sr_q[SR_W-2] != even_par(sr_q));
`else
    assign par_bad_s = 1'b0;
`endif

    assign ir_valid_s = ({1'b0, ir_q} < NUM_CH_W);
    assign upd_take_s = dbg_update & ~busy_q & ir_valid_s;
    assign upd_drop_s = dbg_update & (busy_q | ~ir_valid_s);
    assign set_err_s  = upd_drop_s | (upd_take_s & par_bad_s);

    // Channel decode: readback mux, ack of the latched channel, one-hot of ir.
    always_comb begin
        rd_word_s   = '0;
        ack_s       = 1'b0;
        ir_onehot_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rd_word_s      = (ir_q == k[IR_W-1:0]) ? ch_rdata[k*SR_W +: SR_W] : rd_word_s;
            ack_s          = (cur_ch_q == k[IR_W-1:0]) ? ch_ack[k] : ack_s;
            ir_onehot_s[k] = (ir_q == k[IR_W-1:0]);
        end
    end

    // Next-state for shift path, error flag and command FSM.
    always_comb begin
        state_d    = state_q;
        action_d   = action_q;
        noaction_d = '0;
        busy_d     = busy_q;
        jdo_d      = jdo_q;
        cur_ch_d   = cur_ch_q;

        if (dbg_ir_load) begin
            ir_d = dbg_ir_in;
        end else begin
            ir_d = ir_q;
        end

        // Capture has priority; while busy the readback is replaced by a busy marker.
        if (dbg_capture) begin
            sr_d = busy_q ? SR_BUSY : rd_word_s;
        end else if (dbg_shift) begin
            sr_d = {dbg_tdi, sr_q[SR_W-1:1]};
        end else begin
            sr_d = sr_q;
        end

        if (set_err_s) begin
            err_d = 1'b1;
        end else if (dbg_ir_load && (dbg_ir_in == IR_ONES)) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (upd_take_s) begin
            jdo_d    = sr_q;
            cur_ch_d = ir_q;
        end else begin
            jdo_d    = jdo_q;
            cur_ch_d = cur_ch_q;
        end

        case (state_q)
            ST_ACTION: begin
                if (ack_s) begin
                    state_d  = ST_IDLE;
                    action_d = '0;
                    busy_d   = 1'b0;
                end else begin
                    state_d  = ST_ACTION;
                end
            end
            ST_IDLE, ST_NOACT: begin
                if (upd_take_s && !par_bad_s) begin
                    if (sr_q[SR_W-1]) begin
                        state_d  = ST_ACTION;
                        action_d = ir_onehot_s;
                        busy_d   = 1'b1;
                    end else begin
                        state_d    = ST_NOACT;
                        noaction_d = ir_onehot_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                action_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            cur_ch_q   <= '0;
            sr_q       <= '0;
            jdo_q      <= '0;
            action_q   <= '0;
            noaction_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            cur_ch_q   <= cur_ch_d;
            sr_q       <= sr_d;
            jdo_q      <= jdo_d;
            action_q   <= action_d;
            noaction_q <= noaction_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign dbg_tdo     = sr_q[0];
    assign ch_action   = action_q;
    assign ch_noaction = noaction_q;
    assign jdo         = jdo_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_limbus_cpu_debug_cmd_engine.sv
// Bench for limbus_cpu_debug_cmd_engine: two instances (NUM_CH=4 and NUM_CH=3) driven in lockstep
// and compared every cycle against a channel/queue-level reference model, plus directed pins.
module tb_limbus_cpu_debug_cmd_engine;
    localparam int SR = 38;

    logic            clk = 1'b0;
    logic            reset;
    logic            dbg_ir_load;
    logic [1:0]      dbg_ir_in;
    logic            dbg_capture;
    logic            dbg_shift;
    logic            dbg_tdi;
    logic            dbg_update;
    logic [4*SR-1:0] ch_rdata;
    logic [3:0]      ch_ack;

    logic          tdo4, busy4, err4, tdo3, busy3, err3;
    logic [3:0]    act4, noa4;
    logic [2:0]    act3, noa3;
    logic [SR-1:0] jdo4, jdo3;

    limbus_cpu_debug_cmd_engine #(.IR_W(2), .SR_W(SR), .NUM_CH(4)) u_dut4 (
        .clk(clk), .reset(reset), .dbg_ir_load(dbg_ir_load), .dbg_ir_in(dbg_ir_in),
        .dbg_capture(dbg_capture), .dbg_shift(dbg_shift), .dbg_tdi(dbg_tdi), .dbg_tdo(tdo4),
        .dbg_update(dbg_update), .ch_rdata(ch_rdata), .ch_ack(ch_ack),
        .ch_action(act4), .ch_noaction(noa4), .jdo(jdo4), .busy(busy4), .err(err4));

    limbus_cpu_debug_cmd_engine #(.IR_W(2), .SR_W(SR), .NUM_CH(3)) u_dut3 (
        .clk(clk), .reset(reset), .dbg_ir_load(dbg_ir_load), .dbg_ir_in(dbg_ir_in),
        .dbg_capture(dbg_capture), .dbg_shift(dbg_shift), .dbg_tdi(dbg_tdi), .dbg_tdo(tdo3),
        .dbg_update(dbg_update), .ch_rdata(ch_rdata[3*SR-1:0]), .ch_ack(ch_ack[2:0]),
        .ch_action(act3), .ch_noaction(noa3), .jdo(jdo3), .busy(busy3), .err(err3));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: pending channel (-1 = none), pulsing channel (-1 = none), per instance.
    int            nch[2] = '{4, 3};
    logic [1:0]    m_ir;
    logic [SR-1:0] m_sr[2];
    logic [SR-1:0] m_jdo[2];
    int            m_pend[2];
    int            m_noact[2];
    bit            m_err[2];

    function automatic logic [SR-1:0] fix(input logic [SR-1:0] w);
        logic [SR-1:0] r;
        r = w;
`ifdef LIMBUS_DBG_PARITY_EN
        r[SR-2] = ^{w[SR-1], w[SR-3:0]};
`endif
        return r;
    endfunction

    function automatic bit par_bad(input logic [SR-1:0] w);
`ifdef LIMBUS_DBG_PARITY_EN
        return w[SR-2] != (^{w[SR-1], w[SR-3:0]});
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        logic [1:0]    ir_o;
        logic [SR-1:0] sr_o;
        bit            bsy;
        bit            eset;
        int            pend_n;
        int            noact_n;
        ir_o = m_ir;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_sr[d] = '0; m_jdo[d] = '0; m_pend[d] = -1; m_noact[d] = -1; m_err[d] = 1'b0;
                continue;
            end
            sr_o    = m_sr[d];
            bsy     = (m_pend[d] >= 0);
            pend_n  = m_pend[d];
            noact_n = -1;
            eset    = 1'b0;
            if (bsy && ch_ack[m_pend[d]]) pend_n = -1;
            if (dbg_update) begin
                if (bsy || int'(ir_o) >= nch[d]) begin
                    eset = 1'b1;
                end else begin
                    m_jdo[d] = sr_o;
                    if (par_bad(sr_o)) eset = 1'b1;
                    else if (sr_o[SR-1]) pend_n = int'(ir_o);
                    else noact_n = int'(ir_o);
                end
            end
            if (dbg_capture) begin
                if (bsy) m_sr[d] = fix_busy();
                else if (int'(ir_o) < nch[d]) m_sr[d] = ch_rdata[int'(ir_o)*SR +: SR];
                else m_sr[d] = '0;
            end else if (dbg_shift) begin
                m_sr[d] = (sr_o >> 1) | (SR'(dbg_tdi) << (SR-1));
            end
            if (eset) m_err[d] = 1'b1;
            else if (dbg_ir_load && dbg_ir_in == 2'd3) m_err[d] = 1'b0;
            m_pend[d]  = pend_n;
            m_noact[d] = noact_n;
        end
        if (reset) m_ir = 2'd0;
        else if (dbg_ir_load) m_ir = dbg_ir_in;
    endtask

    function automatic logic [SR-1:0] fix_busy();
        logic [SR-1:0] b;
        b = '0;
        b[SR-1] = 1'b1;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] onehot(input int c);
        return (c >= 0) ? (64'd1 << c) : 64'd0;
    endfunction

    task automatic cmp_dut(input int d, input logic tdo, input logic [3:0] act, input logic [3:0] noa,
                           input logic [SR-1:0] jdo, input logic bsy, input logic er);
        string p;
        p = (d == 0) ? "ch4" : "ch3";
        chk({p, ".tdo"},         64'(tdo),  64'(m_sr[d][0]));
        chk({p, ".ch_action"},   64'(act),  onehot(m_pend[d]));
        chk({p, ".ch_noaction"}, 64'(noa),  onehot(m_noact[d]));
        chk({p, ".jdo"},         64'(jdo),  64'(m_jdo[d]));
        chk({p, ".busy"},        64'(bsy),  64'(m_pend[d] >= 0));
        chk({p, ".err"},         64'(er),   64'(m_err[d]));
    endtask

    // Compare process: both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, tdo4, act4, noa4, jdo4, busy4, err4);
            cmp_dut(1, tdo3, {1'b0, act3}, {1'b0, noa3}, jdo3, busy3, err3);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        dbg_ir_load = 1'b0; dbg_capture = 1'b0; dbg_shift = 1'b0; dbg_tdi = 1'b0;
        dbg_update = 1'b0; ch_ack = '0; reset = 1'b0;
    endtask

    task automatic shift_in(input logic [SR-1:0] w);
        for (int i = 0; i < SR; i++) begin
            dbg_shift = 1'b1;
            dbg_tdi   = w[i];
            tick();
        end
    endtask

    task automatic ir_load(input logic [1:0] v);
        dbg_ir_load = 1'b1;
        dbg_ir_in   = v;
        tick();
    endtask

    logic [SR-1:0] w1, w2, w3, w4;

    initial begin
        reset = 1'b1; dbg_ir_load = 1'b0; dbg_ir_in = 2'd0; dbg_capture = 1'b0; dbg_shift = 1'b0;
        dbg_tdi = 1'b0; dbg_update = 1'b0; ch_ack = '0; ch_rdata = '0; m_ir = 2'd0;
        for (int d = 0; d < 2; d++) begin
            m_sr[d] = '0; m_jdo[d] = '0; m_pend[d] = -1; m_noact[d] = -1; m_err[d] = 1'b0;
        end
        reset = 1'b1; tick();
        reset = 1'b1; tick();
        chk_en = 1'b1;
        chk("rst.busy", 64'(busy4), 64'd0);
        chk("rst.err",  64'(err4),  64'd0);
        chk("rst.jdo",  64'(jdo4),  64'd0);

        // Action on channel 2, then acknowledge.
        w1 = fix(38'h20_0000_00AB);
        ir_load(2'd2);
        shift_in(w1);
        chk("act2.tdo", 64'(tdo4), 64'd1);
        dbg_update = 1'b1; tick();
        chk("act2.jdo",  64'(jdo4), 64'(w1));
        chk("act2.act4", 64'(act4), 64'h4);
        chk("act2.act3", 64'(act3), 64'h4);
        chk("act2.busy", 64'(busy4), 64'd1);
        ch_ack = 4'b0100; tick();
        chk("act2.clr.act",  64'(act4), 64'd0);
        chk("act2.clr.busy", 64'(busy4), 64'd0);

        // No-action pulse on channel 1.
        w2 = fix(38'h00_1234_5678);
        ir_load(2'd1);
        shift_in(w2);
        dbg_update = 1'b1; tick();
        chk("noa1.noa",  64'(noa4), 64'h2);
        chk("noa1.busy", 64'(busy4), 64'd0);
        tick();
        chk("noa1.once", 64'(noa4), 64'd0);

        // Dropped update while busy, busy capture marker, err clear.
        w3 = fix(38'h2A_5A5A_5A5A);
        ir_load(2'd0);
        shift_in(w3);
        dbg_update = 1'b1; tick();
        chk("drop.act", 64'(act4), 64'h1);
        dbg_shift = 1'b1; dbg_tdi = 1'b1; tick();
        dbg_update = 1'b1; tick();
        chk("drop.err", 64'(err4), 64'd1);
        chk("drop.jdo", 64'(jdo4), 64'(w3));
        dbg_capture = 1'b1; dbg_shift = 1'b1; tick();
        chk("cap.tdo0", 64'(tdo4), 64'd0);
        for (int i = 0; i < SR - 1; i++) begin
            dbg_shift = 1'b1; tick();
        end
        chk("cap.msb", 64'(tdo4), 64'd1);
        ir_load(2'd3);
        chk("clr.err", 64'(err4), 64'd0);
        ch_ack = 4'b0001; tick();
        chk("drop.ack", 64'(busy4), 64'd0);

        // Out-of-range channel on the three-channel instance.
        dbg_update = 1'b1; tick();
        chk("oor.err", 64'(err3), 64'd1);
        chk("oor.act", 64'(act3), 64'd0);
        chk("oor.noa", 64'(noa3), 64'd0);
        tick();
        ch_ack = 4'b1111; tick();

        // Reset with an action pending, then a late ack.
        w4 = fix(38'h3F_0000_1111);
        ch_rdata[1*SR +: SR] = w4;
        ir_load(2'd1);
        dbg_capture = 1'b1; tick();
        dbg_update = 1'b1; tick();
        chk("rst.pend.act", 64'(act4), 64'h2);
        reset = 1'b1; dbg_update = 1'b1; dbg_ir_load = 1'b1; dbg_ir_in = 2'd2; tick();
        chk("rst.act",  64'(act4),  64'd0);
        chk("rst.busy2", 64'(busy4), 64'd0);
        chk("rst.jdo2", 64'(jdo4),  64'd0);
        ch_ack = 4'b0010; tick();
        chk("late.ack.act", 64'(act4), 64'd0);

`ifdef LIMBUS_DBG_PARITY_EN
        ir_load(2'd2);
        w1 = fix(38'h20_0000_0003);
        w2 = w1;
        w2[SR-2] = ~w2[SR-2];
        shift_in(w2);
        dbg_update = 1'b1; tick();
        chk("par.bad.jdo", 64'(jdo4), 64'(w2));
        chk("par.bad.act", 64'(act4), 64'd0);
        chk("par.bad.noa", 64'(noa4), 64'd0);
        chk("par.bad.err", 64'(err4), 64'd1);
        shift_in(w1);
        dbg_update = 1'b1; tick();
        chk("par.ok.act", 64'(act4), 64'h4);
        ch_ack = 4'b0100; tick();
`endif

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                for (int j = 0; j < 4 * SR; j += 32) ch_rdata[j +: 32] = 32'($urandom);
            end
            reset       = ($urandom_range(0, 199) == 0);
            dbg_ir_load = ($urandom_range(0, 99) < 10);
            dbg_ir_in   = 2'($urandom_range(0, 3));
            dbg_capture = ($urandom_range(0, 99) < 6);
            dbg_shift   = ($urandom_range(0, 99) < 50);
            dbg_tdi     = 1'($urandom);
            dbg_update  = ($urandom_range(0, 99) < 8) && (m_noact[0] < 0) && (m_noact[1] < 0);
            ch_ack      = ($urandom_range(0, 99) < 25) ? 4'($urandom) : 4'd0;
            tick();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
